// File: rtl/adder_pkg.sv
// Shared types and parameter helpers for the serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned calc_steps(input int unsigned width, input int unsigned bpc);
    return (bpc == 0) ? 1 : width / bpc;
  endfunction

  function automatic int unsigned calc_step_w(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned bpc);
    return (width >= 2) && (bpc != 0) && (bpc <= width) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_slice.sv
// BPC-bit ripple-carry slice built from full_adder cells; also exposes the
// carry into its top bit for signed-overflow detection.
module ripple_slice #(
  parameter int unsigned BPC = 1
) (
  input  logic [BPC-1:0] a,
  input  logic [BPC-1:0] b,
  input  logic           cin,
  output logic [BPC-1:0] s,
  output logic           cout,
  output logic           c_top
);

  // Per-bit carry nets keep the chain free of self-referencing vectors.
  for (genvar i = 0; i < BPC; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_bit[i-1].co;
    end
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (ci),
      .s   (s[i]),
      .cout(co)
    );
  end

  assign cout  = g_bit[BPC-1].co;
  assign c_top = g_bit[BPC-1].ci;

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one BPC-bit digit slice per clock through a
// ripple slice, with valid/ready handshakes on input and output.
module serial_addsub
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STEPS  = calc_steps(WIDTH, BPC);
  localparam int unsigned STEP_W = calc_step_w(STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  if (!params_ok(WIDTH, BPC)) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of BPC");
  end

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic [BPC-1:0]    slice_sum_c;
  logic              slice_cout_c;
  logic              slice_ctop_c;
  logic              accept_c;
  logic              last_step_c;

  assign accept_c    = in_valid && in_ready_q;
  assign last_step_c = (step_q == LAST_STEP);

  ripple_slice #(.BPC(BPC)) u_slice (
    .a    (opa_q[BPC-1:0]),
    .b    (opb_q[BPC-1:0]),
    .cin  (carry_q),
    .s    (slice_sum_c),
    .cout (slice_cout_c),
    .c_top(slice_ctop_c)
  );

  // State register with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c)    state_d = ST_RUN;
      ST_RUN:  if (last_step_c) state_d = ST_DONE;
      ST_DONE: if (out_ready)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs follow the state being entered.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_d == ST_IDLE) in_ready_d  = 1'b1;
    if (state_d == ST_DONE) out_valid_d = 1'b1;
  end

  // Datapath: operand capture, per-step shift, result load on the last step.
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          step_d  = '0;
        end
      end
      ST_RUN: begin
        opa_d   = opa_q >> BPC;
        opb_d   = opb_q >> BPC;
        acc_d   = WIDTH'({slice_sum_c, acc_q} >> BPC);
        carry_d = slice_cout_c;
        step_d  = step_q + STEP_W'(1);
        if (last_step_c) begin
          sum_d  = WIDTH'({slice_sum_c, acc_q} >> BPC);
          cout_d = slice_cout_c;
          ovf_d  = slice_ctop_c ^ slice_cout_c;
          step_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      step_q  <= step_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands as a sequence of BPC-bit digit slices, one slice per clock, through a ripple chain of the team's existing full-adder cell. It is the successor to the single-bit combinational full adder. It adds a subtract mode, signed-overflow detection, and valid/ready handshakes on both sides, so it can sit between pipelined datapath stages where area matters more than throughput.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2.
- BPC, 1: bits processed per cycle; must divide WIDTH. STEPS = WIDTH/BPC.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B; sampled with operands.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  final carry-out. For sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready:
    - load opA=a.
    - load opB = sub ? ~b : b.
    - carry=sub, step=0.
    - go to RUN.
- **RUN**
  - in_ready=0, out_valid=0.
  - Each cycle, the BPC LSBs of opA/opB plus the carry feed the ripple chain.
  - The BPC sum bits shift into the top of the sum shift register (LSB-first fill). opA and opB shift right by BPC.
  - carry takes the chain carry-out. step increments.
  - On the last step (step==STEPS−1):
    - cout takes the chain carry-out.
    - ovf = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1). Take the carry into bit WIDTH−1 from inside the chain; when BPC=1, it is the carry register.
    - Go to DONE.
- **DONE**
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are held stable until out_ready=1, then go to IDLE.
  - A new operand is accepted no earlier than the cycle after the return to IDLE.
- in_valid while not in_ready is ignored. The operands are not captured.
- Changes to a, b or sub after acceptance have no effect on the operation in flight.
- Arithmetic:
  - sum = (a + (sub ? ~b : b) + sub) mod 2^WIDTH.
  - cout is the bit WIDTH of the same expression.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0, ovf=0.
  - step=0, carry=0.
- Latency: out_valid rises exactly STEPS cycles after the accepting edge. For WIDTH=8, BPC=1 that is 8 cycles; for BPC=4 it is 2 cycles.
- Minimum initiation interval: STEPS+2 cycles when out_ready is held high.
- sum, cout and ovf remain at their last values after the handshake until the next DONE.
- Reset asserted mid-RUN or in DONE:
  - state, step, sum, cout and ovf return to their reset values immediately.
  - The in-flight result is discarded, and no out_valid pulse follows.
- Combinational path is one BPC-deep ripple chain only. There is no path from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- Shared package adder_pkg:
  - state typedef (IDLE/RUN/DONE).
  - STEPS derivation.
  - Elaboration checks: WIDTH%BPC==0, WIDTH≥2.
- Sub-module ripple_slice:
  - BPC instances of the existing full adder, chained carry.
  - Outputs the BPC sum bits, the carry-out, and the carry into its top bit (needed for ovf).
- Top level holds the FSM, step counter, operand/sum shift registers and handshake logic.

## Test plan
All scenarios use WIDTH=8, BPC=1 unless stated.
- Add a=0x5A, b=0x3C, sub=0, out_ready=1 → out_valid 8 cycles after accept; sum=0x96, cout=0, ovf=1.
- Sub a=0x10, b=0x20 → sum=0xF0, cout=0, ovf=0. Sub a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
- Add a=0xFF, b=0x01 → sum=0x00, cout=1, ovf=0. Then, with BPC=4, a=0x7F, b=0x01 → out_valid 2 cycles after accept; sum=0x80, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, and an in_valid pulse during this time is ignored. Release → IDLE next cycle, then the next operand is accepted.
- Deassert rst_n at RUN step 3 → in_ready=1, out_valid=0, sum=0 immediately. Re-run a=0x01, b=0x02 → sum=0x03.
- Random regression: 1000 operations with random sub/out_ready stalls for BPC ∈ {1, 2, 4, 8}, compared against an arithmetic model for sum, cout and ovf.
